if_id_skid_reg: RTL and testbench

//   IF->ID pipeline stage register with valid/ready handshake and a 1-entry skid buffer.
//   - Captures {pc, instr} from fetch.
//   - Presents them to decode one cycle later.
//   - Absorbs one beat of decode back-pressure without a combinational ready path.
//   - Flush turns the stage into a bubble (NOP) for branch/jump redirect.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/if_id_skid_reg_if.sv | 26 ++
 rtl/if_id_skid_reg_ddf_en_rst.sv | 16 +
 rtl/if_id_skid_reg.sv | 113 +++++++++++
 tb/tb_if_id_skid_reg.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline types and constants for the fetch/decode boundary.
package riscv_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;

  // addi x0,x0,0
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/if_id_skid_reg_if.sv
// Fetch->decode handshake bundle; slave is the stage register, master the surrounding pipeline.
interface if_id_skid_reg_if
  import riscv_pkg::*;
#(
  parameter int unsigned PC_W    = riscv_pkg::PC_W,
  parameter int unsigned INSTR_W = riscv_pkg::INSTR_W
);
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr
  );

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/if_id_skid_reg_ddf_en_rst.sv
// Team enable+reset data register primitive (active-high async reset).
module DDF_en_rst #(
  parameter int unsigned     DW          = 64,
  parameter logic [DW-1:0]   RESET_VALUE = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= RESET_VALUE;
    else if (en) q <= d;
  end
endmodule

// File: rtl/if_id_skid_reg.sv
// IF->ID stage register with registered in_ready and a 1-entry skid buffer.
module if_id_skid_reg
  import riscv_pkg::*;
#(
  parameter int unsigned        PC_W      = riscv_pkg::PC_W,
  parameter int unsigned        INSTR_W   = riscv_pkg::INSTR_W,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  if_id_skid_reg_if.slave  bus
);
  localparam int unsigned DW = PC_W + INSTR_W;

  skid_state_t   r_state;
  skid_state_t   w_state_nxt;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          w_rst;
  logic          w_accept;
  logic          w_consume;
  logic          w_main_en;
  logic          w_skid_en;
  logic [DW-1:0] w_in_beat;
  logic [DW-1:0] w_main_d;
  logic [DW-1:0] r_main_q;
  logic [DW-1:0] r_skid_q;

  assign w_rst     = ~rst;
  assign w_accept  = bus.in_valid & r_in_ready;
  assign w_consume = r_out_valid & bus.out_ready;
  assign w_in_beat = {bus.in_pc, bus.in_instr};

  always_comb begin
    w_state_nxt = r_state;
    w_main_en   = 1'b0;
    w_skid_en   = 1'b0;
    w_main_d    = w_in_beat;
    unique case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt = MAIN;
          w_main_en   = 1'b1;
        end
      end
      MAIN: begin
        if (w_accept && w_consume) begin
          w_main_en   = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = FULL;
          w_skid_en   = 1'b1;
        end else if (w_consume) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_consume) begin
          w_state_nxt = MAIN;
          w_main_en   = 1'b1;
          w_main_d    = r_skid_q;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    // Flush leaves data regs untouched; out_instr is masked to NOP via out_valid instead.
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_en   = 1'b0;
      w_skid_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != FULL);
      r_out_valid <= (w_state_nxt != EMPTY);
    end
  end

  DDF_en_rst #(
    .DW          (DW),
    .RESET_VALUE ({RESET_PC, NOP_INSTR})
  ) u_main (
    .clk (clk),
    .rst (w_rst),
    .en  (w_main_en),
    .d   (w_main_d),
    .q   (r_main_q)
  );

  DDF_en_rst #(
    .DW          (DW),
    .RESET_VALUE ({RESET_PC, NOP_INSTR})
  ) u_skid (
    .clk (clk),
    .rst (w_rst),
    .en  (w_skid_en),
    .d   (w_in_beat),
    .q   (r_skid_q)
  );

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_pc    = r_main_q[DW-1:INSTR_W];
  assign bus.out_instr = r_out_valid ? r_main_q[INSTR_W-1:0] : NOP_INSTR;
endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench for the IF->ID skid stage register.
module tb_if_id_skid_reg;
  import riscv_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  logic flush;
  int   n_vec;
  int   n_err;

  if_id_skid_reg_if bus ();

  if_id_skid_reg u_dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic rdy,
                         input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    chk({tag, ".in_ready"},  {31'd0, bus.in_ready},  {31'd0, rdy});
    chk({tag, ".out_pc"},    bus.out_pc,    pc);
    chk({tag, ".out_instr"}, bus.out_instr, ins);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_instr = ins;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h100, 32'hDEAD);

    // Reset held with a beat offered: discarded
    tick(); tick();
    chk_out("reset", 1'b0, 1'b1, 32'h0, NOP);
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk_out("post_reset", 1'b0, 1'b1, 32'h0, NOP);

    // Streaming
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h0, 32'hA); tick();
    chk_out("stream0", 1'b1, 1'b1, 32'h0, 32'hA);
    drive(1'b1, 32'h4, 32'hB); tick();
    chk_out("stream1", 1'b1, 1'b1, 32'h4, 32'hB);
    drive(1'b1, 32'h8, 32'hC); tick();
    chk_out("stream2", 1'b1, 1'b1, 32'h8, 32'hC);
    drive(1'b0, 32'h0, 32'h0); tick();
    chk_out("stream_drain", 1'b0, 1'b1, 32'h8, NOP);

    // Back-pressure fills the skid
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h10, 32'h10); tick();
    chk_out("bp_main", 1'b1, 1'b1, 32'h10, 32'h10);
    drive(1'b1, 32'h14, 32'h14); tick();
    chk_out("bp_full", 1'b1, 1'b0, 32'h10, 32'h10);
    drive(1'b0, 32'h0, 32'h0); tick();
    chk_out("bp_hold", 1'b1, 1'b0, 32'h10, 32'h10);
    bus.out_ready = 1'b1; tick();
    chk_out("bp_skid_out", 1'b1, 1'b1, 32'h14, 32'h14);
    tick();
    chk_out("bp_empty", 1'b0, 1'b1, 32'h14, NOP);

    // Flush while FULL with an incoming beat
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h30, 32'h30); tick();
    drive(1'b1, 32'h34, 32'h34); tick();
    chk_out("fl_full", 1'b1, 1'b0, 32'h30, 32'h30);
    flush = 1'b1;
    drive(1'b1, 32'h18, 32'h18); tick();
    chk_out("fl_bubble", 1'b0, 1'b1, 32'h30, NOP);
    flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0); tick();
    chk_out("fl_no_stale", 1'b0, 1'b1, 32'h30, NOP);

    // Flush beats a same-cycle accept in EMPTY
    flush = 1'b1;
    drive(1'b1, 32'h1C, 32'h1C); tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk_out("fl_empty_accept", 1'b0, 1'b1, 32'h30, NOP);

    // Simultaneous accept and consume in MAIN
    drive(1'b1, 32'h20, 32'h20); tick();
    chk_out("ac_main", 1'b1, 1'b1, 32'h20, 32'h20);
    drive(1'b1, 32'h24, 32'h24); tick();
    chk_out("ac_next", 1'b1, 1'b1, 32'h24, 32'h24);
    drive(1'b0, 32'h0, 32'h0); tick();
    chk_out("ac_empty", 1'b0, 1'b1, 32'h24, NOP);

    // Async reset mid-cycle while FULL
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h40, 32'h40); tick();
    drive(1'b1, 32'h44, 32'h44); tick();
    chk_out("ar_full", 1'b1, 1'b0, 32'h40, 32'h40);
    drive(1'b0, 32'h0, 32'h0);
    #2 rst = 1'b0;
    #1;
    chk_out("ar_immediate", 1'b0, 1'b1, 32'h0, NOP);
    tick();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk_out("ar_no_stale0", 1'b0, 1'b1, 32'h0, NOP);
    tick();
    chk_out("ar_no_stale1", 1'b0, 1'b1, 32'h0, NOP);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
